// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared board-level types and constants for the LED toggle path
package led_pkg;

    localparam int CLK_HZ           = 100_000_000;
    localparam int DBNC_10MS_CYCLES = 1_000_000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbnc_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with configurable reset value
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two back-to-back flops give metastability a full cycle to resolve
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/push_debounce.sv
// rtl/push_debounce.sv - push-button debouncer with one-cycle press strobe (optional release strobe: PUSH_DEBOUNCE_RELEASE_EN)
module push_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DBNC_10MS_CYCLES,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_in_i,
    output logic push_o,
    output logic btn_level_o
`ifdef PUSH_DEBOUNCE_RELEASE_EN
    ,
    output logic release_o
`endif
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MATCH = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              btn_norm;
    logic              sync2;
    dbnc_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_q, push_d;
    logic              level_q, level_d;
    logic              cnt_match;

    // Everything downstream works in "pressed = 1" terms
    assign btn_norm = BTN_ACTIVE_HIGH ? btn_in_i : ~btn_in_i;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (btn_norm),
        .q_o     (sync2)
    );

    assign cnt_match = (cnt_q == CNT_MATCH);

    // State and stability counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a level change is accepted only after it holds through the full count;
    // an input change is checked before the match, so a flip on the match cycle aborts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_match) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_match) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: strobes fire on the accepting transition, level follows the next state
    always_comb begin
        push_d  = (state_q == PRESS_WAIT) && sync2 && cnt_match;
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // Registered outputs so nothing downstream sees a combinational path from the pin
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            push_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            push_q  <= push_d;
            level_q <= level_d;
        end
    end

    assign push_o      = push_q;
    assign btn_level_o = level_q;

`ifdef PUSH_DEBOUNCE_RELEASE_EN
    logic release_q, release_d;

    // Release strobe mirrors the press strobe on the RELEASE_WAIT -> IDLE transition
    always_comb begin
        release_d = (state_q == RELEASE_WAIT) && !sync2 && cnt_match;
    end

    // Registered release strobe
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            release_q <= 1'b0;
        end else begin
            release_q <= release_d;
        end
    end

    assign release_o = release_q;
`endif

endmodule
